// File: rtl/quad_velocity_if.sv
// Decoder-side bus of quad_velocity: displacement/qualifier inputs and velocity result outputs.
// master drives the measurement inputs; slave is the velocity block.
interface quad_velocity_if #(
  parameter int COUNTER_WIDTH = 32,
  parameter int WINDOW_WIDTH  = 24
);
  logic                     enable;
  logic [WINDOW_WIDTH-1:0]  window_cycles;
  logic [COUNTER_WIDTH-1:0] displacement;
  logic                     clear_displacement;
  logic                     hw_err;
  logic [COUNTER_WIDTH-1:0] velocity;
  logic [COUNTER_WIDTH-1:0] speed;
  logic                     direction;
  logic                     velocity_valid;
  logic                     velocity_err;
  logic                     err_sticky;

  modport master (
    output enable, window_cycles, displacement, clear_displacement, hw_err,
    input  velocity, speed, direction, velocity_valid, velocity_err, err_sticky
  );

  modport slave (
    input  enable, window_cycles, displacement, clear_displacement, hw_err,
    output velocity, speed, direction, velocity_valid, velocity_err, err_sticky
  );
endinterface

// File: rtl/quad_velocity.sv
// Windowed delta of the decoder displacement -> velocity/speed/direction; QUAD_VELOCITY_AVG_EN averages the last 4 windows.
// Result registered one cycle after each window sample as a one-cycle strobe; no backpressure.
module quad_velocity #(
  parameter int COUNTER_WIDTH = 32,
  parameter int WINDOW_WIDTH  = 24
) (
  input logic            clk,
  input logic            rst_n,
  quad_velocity_if.slave bus
);
  localparam logic [COUNTER_WIDTH-1:0] SPEED_MAX = {1'b0, {(COUNTER_WIDTH-1){1'b1}}};
  localparam logic [COUNTER_WIDTH-1:0] VEL_MIN   = {1'b1, {(COUNTER_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                     capture;
  logic                     sample;
  logic                     count;
  logic [WINDOW_WIDTH-1:0]  neff;
  logic [WINDOW_WIDTH-1:0]  cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] last_q, last_d;
  logic [COUNTER_WIDTH-1:0] delta;
  logic [COUNTER_WIDTH-1:0] result;
  logic                     werr_q, werr_d;
  logic                     win_err;
  logic                     res_err;
  logic [COUNTER_WIDTH-1:0] vel_q, vel_d;
  logic [COUNTER_WIDTH-1:0] spd_q, spd_d;
  logic                     dir_q, dir_d;
  logic                     vld_q, vld_d;
  logic                     verr_q, verr_d;
  logic                     sticky_q, sticky_d;

  assign neff    = (bus.window_cycles < WINDOW_WIDTH'(2)) ? WINDOW_WIDTH'(2) : bus.window_cycles;
  assign delta   = bus.displacement - last_q;
  // An error in the sampling cycle itself still belongs to the window being closed.
  assign win_err = werr_q | bus.hw_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (!bus.clear_displacement) state_d = PRIME;
        PRIME:   if (!bus.clear_displacement) state_d = RUN;
        RUN:     if (bus.clear_displacement)  state_d = PRIME;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    capture = 1'b0;
    sample  = 1'b0;
    count   = 1'b0;
    if (bus.enable && !bus.clear_displacement) begin
      unique case (state_q)
        PRIME: capture = 1'b1;
        RUN: begin
          if (cnt_q == WINDOW_WIDTH'(1)) begin
            sample = 1'b1;
          end else begin
            count = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    werr_d = werr_q;
    if (capture || sample) begin
      last_d = bus.displacement;
      cnt_d  = neff;
      werr_d = 1'b0;
    end else if (count) begin
      cnt_d = cnt_q - WINDOW_WIDTH'(1);
      if (bus.hw_err) begin
        werr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      last_q <= '0;
      werr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      werr_q <= werr_d;
    end
  end

`ifdef QUAD_VELOCITY_AVG_EN
  localparam int SUM_WIDTH = COUNTER_WIDTH + 2;

  logic [3:0][COUNTER_WIDTH-1:0] hist_q, hist_d;
  logic [2:0]                    herr_q, herr_d;
  logic [SUM_WIDTH-1:0]          sum_q, sum_d;
  logic [SUM_WIDTH-1:0]          sum_new;

  // Running sum of the last 4 deltas; the mean always fits COUNTER_WIDTH, so dropping 2 LSBs is the floor divide.
  assign sum_new = sum_q + {{2{delta[COUNTER_WIDTH-1]}}, delta}
                         - {{2{hist_q[3][COUNTER_WIDTH-1]}}, hist_q[3]};
  assign result  = sum_new[SUM_WIDTH-1:2];
  assign res_err = win_err | (|herr_q);

  always_comb begin
    hist_d = hist_q;
    herr_d = herr_q;
    sum_d  = sum_q;
    if (state_q == PRIME) begin
      hist_d = '0;
      herr_d = '0;
      sum_d  = '0;
    end else if (sample) begin
      hist_d = {hist_q[2:0], delta};
      herr_d = {herr_q[1:0], win_err};
      sum_d  = sum_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
      herr_q <= '0;
      sum_q  <= '0;
    end else begin
      hist_q <= hist_d;
      herr_q <= herr_d;
      sum_q  <= sum_d;
    end
  end
`else
  assign result  = delta;
  assign res_err = win_err;
`endif

  always_comb begin
    vel_d    = vel_q;
    spd_d    = spd_q;
    dir_d    = dir_q;
    verr_d   = verr_q;
    vld_d    = sample;
    sticky_d = bus.enable & (sticky_q | bus.hw_err);
    if (sample) begin
      vel_d  = result;
      dir_d  = result[COUNTER_WIDTH-1];
      verr_d = res_err;
      // The most negative value has no positive twin; clamp its magnitude.
      if (result == VEL_MIN) begin
        spd_d = SPEED_MAX;
      end else if (result[COUNTER_WIDTH-1]) begin
        spd_d = -result;
      end else begin
        spd_d = result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vel_q    <= '0;
      spd_q    <= '0;
      dir_q    <= 1'b0;
      vld_q    <= 1'b0;
      verr_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      vel_q    <= vel_d;
      spd_q    <= spd_d;
      dir_q    <= dir_d;
      vld_q    <= vld_d;
      verr_q   <= verr_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.velocity       = vel_q;
  assign bus.speed          = spd_q;
  assign bus.direction      = dir_q;
  assign bus.velocity_valid = vld_q;
  assign bus.velocity_err   = verr_q;
  assign bus.err_sticky     = sticky_q;

endmodule

// File: tb/tb_quad_velocity.sv
// Self-checking bench for quad_velocity: directed scenarios plus a randomized run against a window-level reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge after each rising edge.
module tb_quad_velocity;
  localparam int CW   = 32;
  localparam int WW   = 24;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  quad_velocity_if #(.COUNTER_WIDTH(CW), .WINDOW_WIDTH(WW)) bus ();

  quad_velocity #(.COUNTER_WIDTH(CW), .WINDOW_WIDTH(WW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-edge record of what was applied, used by the window model.
  int          e = 0;
  logic [CW-1:0] hist [MAXE];
  bit          errh [MAXE];

  bit          active = 1'b0;
  int          cap    = -1;
  int          prev_s = -1;
  int          next_s = -1;
  longint      dq[$];
  bit          eq[$];
  logic [CW-1:0] x_vel = '0, x_spd = '0;
  bit          x_dir = 1'b0, x_vld = 1'b0, x_err = 1'b0, x_sticky = 1'b0;

  int          nstrobe = 0, first_e = -1, last_e = -1;
  logic [CW-1:0] o_vel = '0, o_spd = '0;
  logic        o_dir = 1'b0;
  logic [7:0]  o_errs = '0;
  logic [CW-1:0] o_vals[$];

  logic [CW-1:0] avg_exp [5];
  logic [2:0]    err_exp;
  int            e_clr;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic int neff_of(input logic [WW-1:0] wc);
    return (wc < 2) ? 2 : int'(wc);
  endfunction

  task automatic model_update();
    longint d, v, a, sum;
    bit w;
    x_vld = 1'b0;
    if (!rst_n) begin
      active = 1'b0; x_vel = '0; x_spd = '0; x_dir = 1'b0; x_err = 1'b0; x_sticky = 1'b0;
    end else if (!bus.enable) begin
      active = 1'b0; x_sticky = 1'b0;
    end else begin
      if (bus.hw_err) x_sticky = 1'b1;
      if (!active) begin
        if (!bus.clear_displacement) begin
          active = 1'b1; cap = e + 1;
        end
      end else if (bus.clear_displacement) begin
        cap = e + 1;
      end else if (e == cap) begin
        prev_s = e; next_s = e + neff_of(bus.window_cycles);
        dq.delete(); eq.delete();
      end else if (e == next_s) begin
        d = longint'($signed(hist[e] - hist[prev_s]));
        w = 1'b0;
        for (int k = prev_s + 1; k <= e; k++) w |= errh[k];
        dq.push_front(d); eq.push_front(w);
        if (dq.size() > 4) begin
          void'(dq.pop_back()); void'(eq.pop_back());
        end
`ifdef QUAD_VELOCITY_AVG_EN
        sum = 0;
        foreach (dq[i]) sum += dq[i];
        v = sum >>> 2;
        w = 1'b0;
        foreach (eq[i]) w |= eq[i];
`else
        sum = d;
        v = sum;
`endif
        a = (v < 0) ? -v : v;
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        x_vld = 1'b1; x_vel = v[CW-1:0]; x_spd = a[CW-1:0]; x_dir = (v < 0); x_err = w;
        prev_s = e; next_s = e + neff_of(bus.window_cycles);
      end
    end
  endtask

  task automatic check_all();
    chk("valid",      32'(bus.velocity_valid), 32'(x_vld));
    chk("velocity",   bus.velocity, x_vel);
    chk("speed",      bus.speed, x_spd);
    chk("direction",  32'(bus.direction), 32'(x_dir));
    chk("err_sticky", 32'(bus.err_sticky), 32'(x_sticky));
    if (x_vld) chk("velocity_err", 32'(bus.velocity_err), 32'(x_err));
    if (bus.velocity_valid === 1'b1) begin
      nstrobe++;
      if (first_e < 0) first_e = e;
      last_e = e;
      o_vel = bus.velocity; o_spd = bus.speed; o_dir = bus.direction;
      o_errs = {o_errs[6:0], bus.velocity_err};
      o_vals.push_back(bus.velocity);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    e++;
    if (e >= MAXE) begin
      $display("FAIL edge_budget observed=%0d required<%0d", e, MAXE);
      $fatal(1);
    end
    hist[e] = bus.displacement;
    errh[e] = bus.hw_err;
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic restart(input logic [WW-1:0] wc, input logic [CW-1:0] d0);
    bus.enable = 1'b0; bus.hw_err = 1'b0; bus.clear_displacement = 1'b0;
    tick();
    bus.window_cycles = wc; bus.displacement = d0; bus.enable = 1'b1;
    nstrobe = 0; first_e = -1; last_e = -1; o_vals.delete(); o_errs = '0;
  endtask

  task automatic step(input int ncyc, input int p, input logic [CW-1:0] s, input int err_at, input bit rnd);
    for (int c = 0; c < ncyc; c++) begin
      if (rnd) begin
        if (bus.clear_displacement) bus.displacement = '0;
        else if ($urandom_range(0, 63) == 0) bus.displacement = bus.displacement + $urandom();
        else bus.displacement = bus.displacement + CW'($urandom_range(0, 8)) - 32'd4;
        bus.hw_err             = ($urandom_range(0, 29) == 0);
        bus.clear_displacement = ($urandom_range(0, 99) == 0);
        bus.enable             = ($urandom_range(0, 149) != 0);
        if ($urandom_range(0, 49) == 0) bus.window_cycles = WW'($urandom_range(0, 12));
      end else begin
        if ((c % p) == p - 1) bus.displacement = bus.displacement + s;
        bus.hw_err = (c == err_at);
      end
      tick();
    end
    bus.hw_err = 1'b0; bus.clear_displacement = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
`ifdef QUAD_VELOCITY_AVG_EN
    avg_exp = '{32'd2, 32'd5, 32'd7, 32'd10, 32'd10};
    err_exp = 3'b011;
`else
    avg_exp = '{32'd10, 32'd10, 32'd10, 32'd10, 32'd10};
    err_exp = 3'b010;
`endif
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.window_cycles = WW'(100); bus.displacement = '0;
    bus.clear_displacement = 1'b0; bus.hw_err = 1'b0;
    tick(); tick(); tick();
    chk("rst_velocity_err", 32'(bus.velocity_err), 32'd0);
    chk("rst_velocity",     bus.velocity, 32'd0);
    rst_n = 1'b1;

    // +1 every 10 cycles, N=100
    restart(100, 32'd0);
    step(405, 10, 32'd1, -1, 1'b0);
    chk("tp1_count", 32'(nstrobe), 32'd4);
    chk("tp1_vel",   o_vel, 32'd10);
    chk("tp1_speed", o_spd, 32'd10);
    chk("tp1_dir",   32'(o_dir), 32'd0);
    chk("tp1_err",   32'(o_errs[0]), 32'd0);

    // -1 every 5 cycles, N=100
    restart(100, 32'd1000);
    step(405, 5, 32'hFFFF_FFFF, -1, 1'b0);
    chk("tp2_vel",   o_vel, 32'hFFFF_FFEC);
    chk("tp2_speed", o_spd, 32'd20);
    chk("tp2_dir",   32'(o_dir), 32'd1);

    // Wrap through zero, N=50
    restart(50, 32'hFFFF_FFF0);
    step(205, 50, 32'h20, -1, 1'b0);
    chk("wrap_count", 32'(nstrobe), 32'd4);
    chk("wrap_vel",   o_vel, 32'h20);
    chk("wrap_speed", o_spd, 32'h20);
    chk("wrap_dir",   32'(o_dir), 32'd0);

    // hw_err inside window 2 of 3, N=40
    restart(40, 32'd7);
    step(125, 1, 32'd0, 60, 1'b0);
    chk("err_count",   32'(nstrobe), 32'd3);
    chk("err_windows", 32'(o_errs[2:0]), 32'(err_exp));
    chk("sticky_hold", 32'(bus.err_sticky), 32'd1);
    bus.enable = 1'b0;
    tick();
    chk("sticky_clr",  32'(bus.err_sticky), 32'd0);

    // clear_displacement 30 cycles into an N=100 window
    restart(100, 32'd0);
    step(31, 10, 32'd1, -1, 1'b0);
    chk("clr_pre_count", 32'(nstrobe), 32'd0);
    bus.clear_displacement = 1'b1;
    tick();
    e_clr = e;
    bus.clear_displacement = 1'b0; bus.displacement = '0;
    step(105, 10, 32'd1, -1, 1'b0);
    chk("clr_count",       32'(nstrobe), 32'd1);
    chk("clr_first_strobe", 32'(first_e), 32'(e_clr + 101));

    // window_cycles=0 behaves as 2
    restart(0, 32'd0);
    step(20, 1, 32'd3, -1, 1'b0);
    chk("w0_count",   32'(nstrobe), 32'd9);
    chk("w0_spacing", 32'(last_e - first_e), 32'd16);
    chk("w0_vel",     o_vel, 32'd6);

    // Most negative delta saturates speed
    restart(10, 32'd0);
    step(45, 10, 32'h8000_0000, -1, 1'b0);
    chk("sat_vel",   o_vel, 32'h8000_0000);
    chk("sat_speed", o_spd, 32'h7FFF_FFFF);
    chk("sat_dir",   32'(o_dir), 32'd1);

    // Reset 60 cycles into an N=100 window
    restart(100, 32'd0);
    step(60, 10, 32'd1, -1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("rstmid_valid", 32'(bus.velocity_valid), 32'd0);
    chk("rstmid_vel",   bus.velocity, 32'd0);
    chk("rstmid_speed", bus.speed, 32'd0);
    rst_n = 1'b1;

    // Constant 10 per window: strobe sequence
    restart(20, 32'd0);
    step(105, 2, 32'd1, -1, 1'b0);
    chk("seq_count", 32'(nstrobe), 32'd5);
    for (int i = 0; i < 5 && i < o_vals.size(); i++) chk("seq_val", o_vals[i], avg_exp[i]);

    // Randomized run
    restart(5, $urandom());
    step(3000, 1, 32'd0, -1, 1'b1);
    bus.enable = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/quad_velocity.md
Name: quad_velocity

Overview:
Downstream consumer of the quadrature decoder. Samples the decoder's free-running displacement count over a programmable window of clock cycles and produces a signed per-window delta (velocity), plus magnitude, direction and error qualification. Output is a registered one-cycle valid strobe per completed window, for the register interface or a control loop.

Parameters:
COUNTER_WIDTH, 32, width of displacement input and velocity outputs (matches decoder)
WINDOW_WIDTH, 24, width of window_cycles and the internal window counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
enable  in  1  run measurement; low forces IDLE
window_cycles  in  WINDOW_WIDTH  window length N in clk cycles; sampled at each window start
displacement  in  COUNTER_WIDTH  decoder displacement count (two's complement, wraps)
clear_displacement  in  1  same strobe that drives the decoder's clear; discards current window
hw_err  in  1  decoder illegal-transition flag
velocity  out  COUNTER_WIDTH  signed delta displacement over last window
speed  out  COUNTER_WIDTH  |velocity|, saturated
direction  out  1  1 = velocity negative
velocity_valid  out  1  one-cycle strobe, new result
velocity_err  out  1  hw_err seen during the reported window; qualified by velocity_valid
err_sticky  out  1  set by any hw_err while enabled; cleared only by reset or enable low

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; velocity, speed, direction, velocity_valid, velocity_err, err_sticky = 0; window counter and last-sample register = 0. Reset mid-window abandons the window, no strobe.
- States: IDLE, PRIME, RUN.
- IDLE: outputs hold last values, velocity_valid 0. enable=1 and clear_displacement=0 -> PRIME.
- PRIME (one cycle): last <= displacement; cnt <= Neff; window error flag cleared -> RUN.
- Neff = window_cycles clamped to minimum 2 (0 and 1 behave as 2).
- RUN: each cycle cnt decrements. hw_err=1 sets the window error flag and err_sticky. When cnt==1: delta = displacement - last, modulo 2^COUNTER_WIDTH; last <= displacement; cnt <= Neff from current window_cycles; window error flag cleared (a hw_err in this same cycle counts toward the finished window). Successive samples are exactly Neff cycles apart.
- Output latency: results are registered on the cycle after the cnt==1 sample. velocity=delta, direction=delta[MSB], speed=|delta|; the most negative value saturates speed to 2^(COUNTER_WIDTH-1)-1. velocity_valid=1 for exactly one cycle, with velocity_err carrying the window error flag.
- clear_displacement=1 in RUN or PRIME: window discarded (no strobe) -> PRIME on the first cycle clear_displacement is 0. The new baseline is captured after the decoder has cleared.
- enable=0 in any state: -> IDLE next cycle, window discarded, err_sticky cleared. A strobe already registered still completes its single cycle.
- Simultaneous clear_displacement and cnt==1: clear wins, no strobe.
- window_cycles change mid-window: no effect until the next reload.

Optional Feature:
Macro QUAD_VELOCITY_AVG_EN.
- Defined: velocity reports the arithmetic mean of the last 4 window deltas. Running sum is COUNTER_WIDTH+2 bits, arithmetic shift right 2. Speed and direction derive from the averaged value. History is zeroed on entering PRIME, and the first 3 strobes after PRIME average in the zeros. velocity_err is the OR of the error flags of the 4 windows.
- Undefined: single-window delta as above; no history registers.

Test Plan:
- N=100; displacement +1 every 10 cycles -> velocity_valid every 100 cycles, velocity=10, speed=10, direction=0, velocity_err=0.
- N=100; displacement -1 every 5 cycles -> velocity=0xFFFFFFEC, speed=20, direction=1.
- Wrap: displacement starts 0xFFFFFFF0, +0x20 over one window of N=50 -> velocity=0x00000020, speed=0x20, direction=0.
- hw_err pulse mid-window 2 of 3 (N=40) -> window 2 strobe has velocity_err=1, windows 1 and 3 have 0; err_sticky=1 from the pulse until enable low.
- clear_displacement at cycle 30 of N=100 -> no strobe for that window; next strobe exactly 100 cycles after the PRIME cycle. window_cycles=0 -> strobes every 2 cycles.
- rst_n low at cycle 60 of N=100 -> all outputs 0 next cycle, no strobe; with QUAD_VELOCITY_AVG_EN and constant 10/window -> strobes 2,5,7,10,10 (truncating shift).
